// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite master: response codes, FSM states and
// the small status structs carried between handshakes.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } master_state_e;

  // Per-command write progress; AW and W may complete in either order.
  typedef struct packed {
    logic aw_done;
    logic w_done;
  } wr_flags_t;

  typedef struct packed {
    axi_resp_e resp;
    logic      timeout;
  } rsp_status_t;

  function automatic logic is_busy(master_state_e s);
    return s inside {StWrReq, StWrResp, StRdAddr, StRdData};
  endfunction

endpackage

// File: rtl/axi_timeout_counter.sv
// Per-transaction watchdog: expired is high in the last allowed busy cycle,
// so the owner can abort on that edge.
module axi_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable && !expired) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    assign expired = enable && (cnt_q == Limit);
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one
// response out, with a watchdog that forces a response if the slave stalls.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  master_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  wr_flags_t             flags_q;
  rsp_status_t           status_q;

  logic busy, expired;
  logic cmd_fire, aw_fire, w_fire, b_fire, r_fire;
  logic aw_done_now, w_done_now;

  assign busy        = is_busy(state_q);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign aw_fire     = awvalid && awready;
  assign w_fire      = wvalid && wready;
  assign b_fire      = bvalid && bready;
  assign r_fire      = rvalid && rready;
  assign aw_done_now = flags_q.aw_done || aw_fire;
  assign w_done_now  = flags_q.w_done || w_fire;

  axi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cmd_fire),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A handshake that completes in the expiry cycle wins over the abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_valid) state_d = cmd_write ? StWrReq : StRdAddr;
      StWrReq:  if (aw_done_now && w_done_now) state_d = StWrResp;
                else if (expired) state_d = StRsp;
      StWrResp: if (bvalid || expired) state_d = StRsp;
      StRdAddr: if (arready) state_d = StRdData;
                else if (expired) state_d = StRsp;
      StRdData: if (rvalid || expired) state_d = StRsp;
      StRsp:    if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    awvalid   = (state_q == StWrReq) && !flags_q.aw_done;
    wvalid    = (state_q == StWrReq) && !flags_q.w_done;
    bready    = (state_q == StWrResp);
    arvalid   = (state_q == StRdAddr);
    rready    = (state_q == StRdData);
    rsp_valid = (state_q == StRsp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      flags_q  <= '0;
      status_q <= '{resp: OKAY, timeout: 1'b0};
    end else begin
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        flags_q <= '0;
      end else if (state_q == StWrReq) begin
        flags_q <= '{aw_done: aw_done_now, w_done: w_done_now};
      end

      if (b_fire) begin
        rdata_q  <= '0;
        status_q <= '{resp: axi_resp_e'(bresp), timeout: 1'b0};
      end else if (r_fire) begin
        rdata_q  <= rdata;
        status_q <= '{resp: axi_resp_e'(rresp), timeout: 1'b0};
      end else if (busy && expired && state_d == StRsp) begin
        rdata_q  <= '0;
        status_q <= '{resp: SLVERR, timeout: 1'b1};
      end
    end
  end

  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign wdata       = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = status_q.resp;
  assign rsp_timeout = status_q.timeout;

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master against a small behavioural AXI-Lite slave.
module tb_axi_lite_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   rsp_cyc = 0;

  // Slave knobs and state
  int          w_low = 0;
  int          w_wait = 0;
  bit          b_block = 0;
  bit          ar_block = 0;
  logic [1:0]  rresp_knob = 2'b00;
  int          n_b = 0;
  bit          aw_got, w_got, b_active, r_active;
  logic [31:0] aw_a, w_d, r_d;
  logic [31:0] mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL sim_watchdog: got no finish, required finish before 100000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_axi_handshakes"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk({tag, "_addr_data"}, {awaddr, wdata, araddr}, 0);
  endtask

  // Behavioural slave: samples handshakes on the rising edge, drives on the falling edge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_got = 0; w_got = 0; b_active = 0; r_active = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        aw_got = 0; w_got = 0; b_active = 0; r_active = 0; w_wait = 0;
      end else begin
        if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; end
        if (wvalid && wready) begin w_got = 1; w_d = wdata; w_wait = 0; end
        else if (wvalid) w_wait++;
        if (bvalid && bready) begin b_active = 0; n_b++; end
        if (rvalid && rready) r_active = 0;
        if (aw_got && w_got) begin
          mem[aw_a] = w_d;
          aw_got = 0; w_got = 0;
          b_active = !b_block;
        end
        if (arvalid && arready) begin
          r_active = 1;
          r_d = mem.exists(araddr) ? mem[araddr] : (araddr ^ 32'hA5A5_0000);
        end
      end
      @(negedge clk);
      awready = 1;
      wready  = (w_wait >= w_low);
      bvalid  = b_active;
      bresp   = 2'b00;
      arready = !ar_block;
      rvalid  = r_active;
      rdata   = r_active ? r_d : 32'h0;
      rresp   = r_active ? rresp_knob : 2'b00;
    end
  end

  // Response monitor: pops the scoreboard on each response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got response %0h/%0h, required none", rsp_rdata, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", rsp_resp, e.resp);
          chk("rsp_timeout", rsp_timeout, e.timeout);
        end
        rsp_cnt++;
        rsp_cyc = cyc;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int acc);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    acc = cyc;
    cmd_valid = 0;
    chk("cmd_accepted", ok, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 60 && rsp_cnt < target; i++) @(negedge clk);
    chk("rsp_arrived", rsp_cnt, target);
  endtask

  task automatic push(input logic [31:0] rd, input logic [1:0] rs, input logic to);
    exp_t e;
    e.rdata = rd; e.resp = rs; e.timeout = to;
    exp_q.push_back(e);
  endtask

  initial begin
    int acc, rel, aw_cnt, w_cnt, ar_cnt, nb0;
    bit saw_bready;
    rst_n = 0; rsp_ready = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Zero-wait write
    push(32'h0, 2'b00, 1'b0);
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, acc);
    chk("wr_aw_w_valid_n1", {awvalid, wvalid}, 2'b11);
    wait_rsp(1);
    chk("wr_rsp_latency", rsp_cyc - acc, 2);

    // Read back
    push(32'hDEAD_BEEF, 2'b00, 1'b0);
    issue(1'b0, 32'h0000_0010, 32'h0, acc);
    chk("rd_arvalid_n1", arvalid, 1);
    chk("rd_araddr", araddr, 32'h10);
    wait_rsp(2);
    chk("rd_rsp_latency", rsp_cyc - acc, 2);

    // W channel stalled while AW completes at once
    w_low = 5;
    repeat (2) @(negedge clk);
    nb0 = n_b;
    push(32'h0, 2'b00, 1'b0);
    issue(1'b1, 32'h0000_0020, 32'h0BAD_F00D, acc);
    aw_cnt = 0; w_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (awvalid) aw_cnt++;
      if (wvalid) w_cnt++;
      if (rsp_cnt == 3) break;
      @(negedge clk);
    end
    chk("stall_awvalid_cycles", aw_cnt, 1);
    chk("stall_wvalid_cycles", w_cnt, 6);
    wait_rsp(3);
    repeat (2) @(negedge clk);
    chk("stall_b_count", n_b - nb0, 1);
    w_low = 0;

    // Slave error passes through
    rresp_knob = 2'b11;
    @(negedge clk);
    push(32'hA5A5_0040, 2'b11, 1'b0);
    issue(1'b0, 32'h0000_0040, 32'h0, acc);
    wait_rsp(4);
    rresp_knob = 2'b00;

    // Watchdog abort on a read that never gets arready
    ar_block = 1;
    @(negedge clk);
    push(32'h0, 2'b10, 1'b1);
    issue(1'b0, 32'h0000_0080, 32'h0, acc);
    ar_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (arvalid) ar_cnt++;
      if (rsp_cnt == 5) break;
      @(negedge clk);
    end
    chk("timeout_arvalid_cycles", ar_cnt, 16);
    wait_rsp(5);
    chk("timeout_rsp_latency", rsp_cyc - acc, 16);
    ar_block = 0;
    @(negedge clk);

    // Reset while waiting for B
    b_block = 1; rsp_ready = 0;
    @(negedge clk);
    issue(1'b1, 32'h0000_0030, 32'h5555_AAAA, acc);
    saw_bready = 0;
    for (int i = 0; i < 20; i++) begin
      if (bready) begin saw_bready = 1; break; end
      @(negedge clk);
    end
    chk("reset_reached_wr_resp", saw_bready, 1);
    rst_n = 0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    b_block = 0; rsp_ready = 1;
    rst_n = 1;
    rel = cyc;
    push(32'h0, 2'b00, 1'b0);
    issue(1'b1, 32'h0000_0050, 32'h1234_5678, acc);
    chk("post_reset_accept_edge", acc - rel, 1);
    wait_rsp(6);

    push(32'h1234_5678, 2'b00, 1'b0);
    issue(1'b0, 32'h0000_0050, 32'h0, acc);
    wait_rsp(7);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite master that sits directly upstream of our AXI-Lite slave. It converts a simple valid/ready command port (one read or write per command) into AXI-Lite address, data and response handshakes. It returns the result on a valid/ready response port. A per-transaction watchdog guarantees a response even when the slave never answers.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/awaddr/araddr
- DATA_WIDTH, 32, width of data buses
- TIMEOUT_CYCLES, 256, cycles allowed per transaction before abort; 0 disables the watchdog

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  out  2  AXI response code
- rsp_timeout  out  1  transaction aborted by watchdog
- awaddr/awvalid out, awready in  AW channel
- wdata/wvalid out, wready in  W channel
- bresp/bvalid in, bready out  B channel
- araddr/arvalid out, arready in  AR channel
- rdata/rresp/rvalid in, rready out  R channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the block registers addr, wdata and write. It goes to WR_REQ if write, else RD_ADDR. cmd_ready=0 in every other state.
- WR_REQ: awvalid and wvalid both rise on entry. Each drops independently on its own handshake (aw_done/w_done flags). Either order is legal, and so is the same cycle. When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp and set rsp_rdata=0, then go to RSP.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata/rresp and go to RSP.
- RSP: rsp_valid=1 with rsp_rdata, rsp_resp and rsp_timeout held stable until rsp_ready. Then return to IDLE.
- awaddr/wdata/araddr are driven from the registered command and are stable while the matching valid is high.
- Watchdog: the counter clears on leaving IDLE and increments each cycle in WR_REQ/WR_RESP/RD_ADDR/RD_DATA. When it reaches TIMEOUT_CYCLES, the block:
  - deasserts all AXI valid/ready outputs;
  - enters RSP with rsp_resp=SLVERR (2'b10), rsp_timeout=1, rsp_rdata=0.
- An abandoned handshake is a deliberate recovery action. The block does not track late responses after an abort.
- A completing handshake takes priority over timeout expiry in the same cycle.
- Slave error codes (SLVERR/DECERR) are passed through unchanged with rsp_timeout=0.

## Timing
- Reset values: cmd_ready=1 (IDLE), and all of the following are 0: rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, awvalid, wvalid, bready, arvalid, rready, awaddr, wdata, araddr.
- Reset mid-transaction drops every valid/ready output immediately (asynchronously) and discards the command.
- Command accepted at edge N: AW/W/AR valid is high in cycle N+1.
- rsp_valid rises the cycle after the B or R handshake edge.
- Zero-wait slave, write: AW/W handshake at N+1; bvalid earliest N+2; rsp_valid earliest N+3.
- Read: AR handshake at N+1; R handshake earliest N+2; rsp_valid earliest N+3.
- Timeout fires exactly TIMEOUT_CYCLES cycles after leaving IDLE; rsp_valid is high the following cycle.
- One transaction in flight; throughput is at most one command per 4 cycles.

## Structure
- Shared package axi_lite_pkg holds:
  - axi_resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - master state enum;
  - the command/response struct typedefs.
- Sub-module axi_timeout_counter: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES. Width is $clog2(TIMEOUT_CYCLES+1). Tied off when TIMEOUT_CYCLES=0.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF to a zero-wait slave → awvalid/wvalid high in cycle N+1 → rsp_valid at N+3 with rsp_resp=00, rsp_rdata=0.
- Read back 0x10 → rsp_rdata=0xDEAD_BEEF, rsp_resp=00, rsp_timeout=0.
- wready held low 5 cycles after awready handshake → awvalid drops after 1 cycle, wvalid stays high 6 cycles, exactly one B accepted.
- Slave returns rresp=11 on read of 0x40 → rsp_resp=11, rsp_timeout=0, rsp_rdata=slave's rdata.
- TIMEOUT_CYCLES=16, slave never asserts arready → arvalid drops after 16 cycles → rsp_valid with rsp_resp=10, rsp_timeout=1, rsp_rdata=0.
- rst_n pulsed low during WR_RESP with rsp_ready stuck low → all outputs at reset values immediately; a new command is accepted on the first cycle after release.
